// File: rtl/reorder_buffer_pkg.sv
// Shared core package: ALU/writeback request types and ROB entry layout.
// Holds the ROB sizing constants used by reorder_buffer and rob_lookup_port.
package reorder_buffer_pkg;

  localparam int ROB_ENTRIES = 8;
  localparam int ROB_ID_W    = 3;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT
  } alu_op_e;

  typedef struct packed {
    alu_op_e               op;
    logic [31:0]           a;
    logic [31:0]           b;
    logic [ROB_ID_W-1:0]   id;
  } alu_req_t;

  typedef struct packed {
    logic                  valid;
    logic [ROB_ID_W-1:0]   id;
    logic [4:0]            rd;
    logic                  rf_wen;
    logic [31:0]           data;
    logic                  xcpt;
    logic [31:0]           pc;
  } wb_req_t;

  typedef struct packed {
    logic                  valid;
    logic                  rf_wen;
    logic [4:0]            rd;
    logic [31:0]           data;
    logic                  xcpt;
    logic [31:0]           pc;
  } rob_entry_t;

  function automatic rob_entry_t wb_to_entry(wb_req_t w);
    rob_entry_t e;
    e.valid  = 1'b1;
    e.rf_wen = w.rf_wen;
    e.rd     = w.rd;
    e.data   = w.data;
    e.xcpt   = w.xcpt;
    e.pc     = w.pc;
    return e;
  endfunction

endpackage

// File: rtl/reorder_buffer_lookup.sv
// ROB operand lookup port: stored-entry hit/data mux.
// With ROB_BYPASS_EN, same-cycle mem/alu writebacks are forwarded too.
module rob_lookup_port
  import reorder_buffer_pkg::*;
(
  input  logic [ROB_ID_W-1:0]          src_id,
  input  rob_entry_t [ROB_ENTRIES-1:0] entries,
  input  wb_req_t                      alu_wb,
  input  wb_req_t                      mem_wb,
  output logic                         hit,
  output logic [31:0]                  data
);

  rob_entry_t e;
  logic       unused_bits;

  assign e = entries[src_id];
  assign unused_bits = ^{e.pc, alu_wb, mem_wb};

  always_comb begin
    hit  = e.valid & e.rf_wen & ~e.xcpt;
    data = e.data;
`ifdef ROB_BYPASS_EN
    // mem is the younger stage's result for the same slot, so it wins
    if (mem_wb.valid && mem_wb.id == src_id) begin
      hit  = mem_wb.rf_wen & ~mem_wb.xcpt;
      data = mem_wb.data;
    end else if (alu_wb.valid && alu_wb.id == src_id) begin
      hit  = alu_wb.rf_wen & ~alu_wb.xcpt;
      data = alu_wb.data;
    end
`endif
    if (!hit) data = '0;
  end

endmodule

// File: rtl/reorder_buffer.sv
// 8-entry reorder buffer: in-order commit, exception flush, operand lookup.
// Optional macro ROB_BYPASS_EN forwards same-cycle writebacks to lookups.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                alu_valid,
  input  logic [ROB_ID_W-1:0] alu_instr_id,
  input  logic [4:0]          alu_rd,
  input  logic                alu_rf_wen,
  input  logic [31:0]         alu_data,
  input  logic                alu_xcpt,
  input  logic [31:0]         alu_pc,
  input  logic                mem_valid,
  input  logic [ROB_ID_W-1:0] mem_instr_id,
  input  logic [4:0]          mem_rd,
  input  logic                mem_rf_wen,
  input  logic [31:0]         mem_data,
  input  logic                mem_xcpt,
  input  logic [31:0]         mem_pc,
  output logic [ROB_ID_W-1:0] rob_tail,
  output logic                rf_wen,
  output logic [4:0]          rf_dest,
  output logic [31:0]         rf_data,
  output logic                xcpt_valid,
  output logic [31:0]         xcpt_pc,
  output logic                flush,
  input  logic [ROB_ID_W-1:0] src1_id,
  input  logic [ROB_ID_W-1:0] src2_id,
  output logic                src1_hit,
  output logic                src2_hit,
  output logic [31:0]         src1_data,
  output logic [31:0]         src2_data
);

  rob_entry_t [ROB_ENTRIES-1:0] rob;
  rob_entry_t                   head;
  wb_req_t                      alu_wb;
  wb_req_t                      mem_wb;
  logic                         commit;
  logic                         xcpt_commit;

  always_comb begin
    alu_wb        = '0;
    alu_wb.valid  = alu_valid & ~flush;
    alu_wb.id     = alu_instr_id;
    alu_wb.rd     = alu_rd;
    alu_wb.rf_wen = alu_rf_wen;
    alu_wb.data   = alu_data;
    alu_wb.xcpt   = alu_xcpt;
    alu_wb.pc     = alu_pc;
    mem_wb        = '0;
    mem_wb.valid  = mem_valid & ~flush;
    mem_wb.id     = mem_instr_id;
    mem_wb.rd     = mem_rd;
    mem_wb.rf_wen = mem_rf_wen;
    mem_wb.data   = mem_data;
    mem_wb.xcpt   = mem_xcpt;
    mem_wb.pc     = mem_pc;
  end

  assign head        = rob[rob_tail];
  assign commit      = head.valid & ~head.xcpt;
  assign xcpt_commit = head.valid & head.xcpt;

  always_ff @(posedge clock) begin
    if (reset) begin
      rob        <= '0;
      rob_tail   <= '0;
      rf_wen     <= 1'b0;
      rf_dest    <= '0;
      rf_data    <= '0;
      xcpt_valid <= 1'b0;
      xcpt_pc    <= '0;
      flush      <= 1'b0;
    end else begin
      rf_wen     <= 1'b0;
      xcpt_valid <= 1'b0;
      flush      <= 1'b0;
      if (xcpt_commit) begin
        // everything behind the faulting tail is younger: drop it all
        xcpt_valid <= 1'b1;
        xcpt_pc    <= head.pc;
        flush      <= 1'b1;
        rob        <= '0;
        rob_tail   <= '0;
      end else begin
        if (commit) begin
          rf_wen        <= head.rf_wen;
          rf_dest       <= head.rd;
          rf_data       <= head.data;
          rob[rob_tail] <= '0;
          rob_tail      <= rob_tail + 3'd1;
        end
        if (alu_wb.valid) rob[alu_wb.id] <= wb_to_entry(alu_wb);
        if (mem_wb.valid) rob[mem_wb.id] <= wb_to_entry(mem_wb);
      end
    end
  end

  rob_lookup_port u_src1 (
    .src_id  (src1_id),
    .entries (rob),
    .alu_wb  (alu_wb),
    .mem_wb  (mem_wb),
    .hit     (src1_hit),
    .data    (src1_data)
  );

  rob_lookup_port u_src2 (
    .src_id  (src2_id),
    .entries (rob),
    .alu_wb  (alu_wb),
    .mem_wb  (mem_wb),
    .hit     (src2_hit),
    .data    (src2_data)
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: directed writes, commit monitor.
// Expectations honour ROB_BYPASS_EN when the bench is built with it.
module tb_reorder_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic [2:0]  alu_instr_id = '0;
  logic [4:0]  alu_rd = '0;
  logic        alu_rf_wen = 1'b0;
  logic [31:0] alu_data = '0;
  logic        alu_xcpt = 1'b0;
  logic [31:0] alu_pc = '0;
  logic        mem_valid = 1'b0;
  logic [2:0]  mem_instr_id = '0;
  logic [4:0]  mem_rd = '0;
  logic        mem_rf_wen = 1'b0;
  logic [31:0] mem_data = '0;
  logic        mem_xcpt = 1'b0;
  logic [31:0] mem_pc = '0;
  logic [2:0]  rob_tail;
  logic        rf_wen;
  logic [4:0]  rf_dest;
  logic [31:0] rf_data;
  logic        xcpt_valid;
  logic [31:0] xcpt_pc;
  logic        flush;
  logic [2:0]  src1_id = '0;
  logic [2:0]  src2_id = '0;
  logic        src1_hit;
  logic        src2_hit;
  logic [31:0] src1_data;
  logic [31:0] src2_data;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          xcpt;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  reorder_buffer dut (
    .clock        (clock),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_instr_id (alu_instr_id),
    .alu_rd       (alu_rd),
    .alu_rf_wen   (alu_rf_wen),
    .alu_data     (alu_data),
    .alu_xcpt     (alu_xcpt),
    .alu_pc       (alu_pc),
    .mem_valid    (mem_valid),
    .mem_instr_id (mem_instr_id),
    .mem_rd       (mem_rd),
    .mem_rf_wen   (mem_rf_wen),
    .mem_data     (mem_data),
    .mem_xcpt     (mem_xcpt),
    .mem_pc       (mem_pc),
    .rob_tail     (rob_tail),
    .rf_wen       (rf_wen),
    .rf_dest      (rf_dest),
    .rf_data      (rf_data),
    .xcpt_valid   (xcpt_valid),
    .xcpt_pc      (xcpt_pc),
    .flush        (flush),
    .src1_id      (src1_id),
    .src2_id      (src2_id),
    .src1_hit     (src1_hit),
    .src2_hit     (src2_hit),
    .src1_data    (src1_data),
    .src2_data    (src2_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input bit x, input logic [4:0] rd,
                              input logic [31:0] d, input logic [31:0] pc);
    exp_t e;
    e.xcpt = x;
    e.rd   = rd;
    e.data = d;
    e.pc   = pc;
    return e;
  endfunction

  // Monitor: every commit/exception pulse must match the queue head.
  always @(negedge clock) begin
    if (!reset && (rf_wen || xcpt_valid || flush)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_commit rf_wen=%0b xcpt_valid=%0b flush=%0b required=none",
                 rf_wen, xcpt_valid, flush);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.xcpt) begin
          chk("xcpt_valid", {31'b0, xcpt_valid}, 32'd1);
          chk("xcpt_pc", xcpt_pc, mon_e.pc);
          chk("xcpt_flush", {31'b0, flush}, 32'd1);
          chk("xcpt_rf_wen", {31'b0, rf_wen}, 32'd0);
        end else begin
          chk("rf_wen", {31'b0, rf_wen}, 32'd1);
          chk("rf_dest", {27'b0, rf_dest}, {27'b0, mon_e.rd});
          chk("rf_data", rf_data, mon_e.data);
          chk("commit_flush", {31'b0, flush}, 32'd0);
        end
      end
    end
  end

  task automatic wr(input bit ua, input bit um, input logic [2:0] id,
                    input logic [4:0] rd, input logic [31:0] ad,
                    input logic [31:0] md, input bit x,
                    input logic [31:0] pc);
    alu_valid = ua; alu_instr_id = id; alu_rd = rd; alu_rf_wen = 1'b1;
    alu_data = ad; alu_xcpt = x; alu_pc = pc;
    mem_valid = um; mem_instr_id = id; mem_rd = rd; mem_rf_wen = 1'b1;
    mem_data = md; mem_xcpt = x; mem_pc = pc;
    @(posedge clock); #1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk("drain_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("rst_tail", {29'b0, rob_tail}, 0);
    chk("rst_rf_wen", {31'b0, rf_wen}, 0);
  endtask

  initial begin
    int n;
    idle(2);
    reset = 1'b0;
    chk("rst_tail", {29'b0, rob_tail}, 0);
    chk("rst_rf_wen", {31'b0, rf_wen}, 0);
    chk("rst_xcpt_valid", {31'b0, xcpt_valid}, 0);
    chk("rst_flush", {31'b0, flush}, 0);
    chk("rst_rf_dest", {27'b0, rf_dest}, 0);
    chk("rst_rf_data", rf_data, 0);
    chk("rst_xcpt_pc", xcpt_pc, 0);

    // single commit, two-cycle latency
    exp_q.push_back(mk(0, 5'd3, 32'h11, 0));
    wr(1, 0, 3'd0, 5'd3, 32'h11, 0, 0, 32'h0);
    chk("t1_tail_early", {29'b0, rob_tail}, 0);
    idle(1);
    chk("t1_tail", {29'b0, rob_tail}, 1);
    drain();

    // out-of-order arrival, in-order commit
    do_reset();
    wr(0, 1, 3'd1, 5'd5, 0, 32'h22, 0, 32'h0);
    idle(3);
    chk("t2_tail_wait", {29'b0, rob_tail}, 0);
    exp_q.push_back(mk(0, 5'd6, 32'h33, 0));
    exp_q.push_back(mk(0, 5'd5, 32'h22, 0));
    wr(1, 0, 3'd0, 5'd6, 32'h33, 0, 0, 32'h0);
    idle(3);
    chk("t2_tail", {29'b0, rob_tail}, 2);
    drain();

    // tail wrap 7 -> 0
    do_reset();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(mk(0, 5'(i + 1), 32'h100 + i, 0));
      wr(1, 0, 3'(i), 5'(i + 1), 32'h100 + i, 0, 0, 32'h0);
    end
    idle(2);
    chk("t3_tail_wrap", {29'b0, rob_tail}, 0);
    exp_q.push_back(mk(0, 5'd9, 32'h200, 0));
    wr(1, 0, 3'd0, 5'd9, 32'h200, 0, 0, 32'h0);
    idle(2);
    chk("t3_tail_after", {29'b0, rob_tail}, 1);
    drain();

    // exception at tail flushes younger entry; flush-cycle write dropped
    do_reset();
    wr(1, 0, 3'd1, 5'd4, 32'h44, 0, 0, 32'h0);
    exp_q.push_back(mk(1, 0, 0, 32'h1000));
    wr(0, 1, 3'd0, 5'd2, 0, 32'h55, 1, 32'h1000);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!flush && n < 10);
    chk("t4_flush_seen", {31'b0, flush}, 1);
    alu_valid = 1'b1; alu_instr_id = 3'd0; alu_rd = 5'd8;
    alu_rf_wen = 1'b1; alu_data = 32'h66; alu_xcpt = 1'b0;
    @(posedge clock); #1;
    alu_valid = 1'b0;
    chk("t4_flush_pulse", {31'b0, flush}, 0);
    chk("t4_tail", {29'b0, rob_tail}, 0);
    src1_id = 3'd1;
    src2_id = 3'd0;
    #1;
    chk("t4_id1_lost", {31'b0, src1_hit}, 0);
    chk("t4_flush_wr_dropped", {31'b0, src2_hit}, 0);
    idle(3);
    drain();

    // lookup: stored, same-cycle, empty, committed
    do_reset();
    wr(1, 0, 3'd2, 5'd1, 32'hAB, 0, 0, 32'h0);
    src1_id = 3'd2;
    #1;
    chk("t5_hit", {31'b0, src1_hit}, 1);
    chk("t5_data", src1_data, 32'hAB);
    alu_valid = 1'b1; alu_instr_id = 3'd3; alu_rd = 5'd1;
    alu_rf_wen = 1'b1; alu_data = 32'hCD; alu_xcpt = 1'b0;
    src2_id = 3'd3;
    #1;
`ifdef ROB_BYPASS_EN
    chk("t5_bypass_hit", {31'b0, src2_hit}, 1);
    chk("t5_bypass_data", src2_data, 32'hCD);
`else
    chk("t5_bypass_hit", {31'b0, src2_hit}, 0);
    chk("t5_bypass_data", src2_data, 0);
`endif
    @(posedge clock); #1;
    alu_valid = 1'b0;
    #1;
    chk("t5_next_hit", {31'b0, src2_hit}, 1);
    chk("t5_next_data", src2_data, 32'hCD);
    src1_id = 3'd5;
    #1;
    chk("t5_empty_hit", {31'b0, src1_hit}, 0);
    chk("t5_empty_data", src1_data, 0);
    exp_q.push_back(mk(0, 5'd7, 32'h77, 0));
    wr(1, 0, 3'd0, 5'd7, 32'h77, 0, 0, 32'h0);
    idle(3);
    src1_id = 3'd0;
    #1;
    chk("t5_committed_hit", {31'b0, src1_hit}, 0);
    chk("t5_tail", {29'b0, rob_tail}, 1);
    drain();

    // reset with pending ids 2,3 discards them
    do_reset();
    src1_id = 3'd2;
    #1;
    chk("t6_reset_discard", {31'b0, src1_hit}, 0);

    // alu and mem collide on id4: mem wins
    wr(1, 1, 3'd4, 5'd9, 32'h5, 32'h6, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(0, 5'(i + 10), 32'h50 + i, 0));
      wr(1, 0, 3'(i), 5'(i + 10), 32'h50 + i, 0, 0, 32'h0);
    end
    exp_q.push_back(mk(0, 5'd9, 32'h6, 0));
    drain();
    idle(2);
    chk("t7_tail", {29'b0, rob_tail}, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
